mux3_rr_arbiter: RTL and testbench
==================================

// Module: mux3_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 3-way datapath resource (driven through a 3:1 select
//  mux) among requesters A, B, C. Issues a one-hot grant plus the 2-bit mux select in the
//  datapath encoding: 2'b10=A, 2'b01=B, 2'b00=C. Holds the grant until the owner signals
//  done or drops its request. Sits beside the mux, between requesting stages and the resource.
// PARAMETERS
//  HOLD_MAX  16  max grant length in cycles (timeout build only); legal 1..2**HOLD_W-1
//  HOLD_W    5   width of hold counter
// PORTS
//  clk       in   1  clock, rising edge
//  arst      in   1  asynchronous reset, active-high
//  req_a     in   1  request from A (level, held until done)
//  req_b     in   1  request from B
//  req_c     in   1  request from C
//  done      in   1  current owner finished; sampled only while busy
//  grant_a   out  1  A owns resource (registered)
//  grant_b   out  1  B owns resource
//  grant_c   out  1  C owns resource
//  select    out  2  mux select: 10=A, 01=B, 00=C; 00 when idle
//  busy      out  1  any grant active (distinguishes idle from grant C)
//  timeout   out  1  one-cycle pulse after forced release
// BEHAVIOUR
//  - Reset (async, immediate): grants=0, select=2'b00, busy=0, timeout=0, hold cnt=0,
//    last-owner pointer=C, so first priority order is A,B,C.
//  - States: IDLE (no grant), GRANT (exactly one grant_x high). grant/select/busy from flops.
//  - Arbitration: search starts at the requester after last owner, order A->B->C->A.
//    Winner's grant rises at the edge after its req is sampled (1-cycle latency).
//  - IDLE->GRANT: any req high at edge. IDLE with no req: stays IDLE.
//  - GRANT release: at edge where owner has done=1 OR owner req=0. Same edge: pointer :=
//    owner; arbitrate remaining reqs (owner included, lowest priority). Winner -> back-to-back
//    grant, no idle cycle; none -> IDLE.
//  - Non-owner reqs never pre-empt. done while IDLE is ignored.
//  - Requests asserted on the release edge take part in that arbitration.
//  - select always consistent with grant in same cycle; never two grants high.
//  - Reset mid-grant: grant dropped asynchronously; on release, arbitration restarts at A.
// CONFIGURATION
//  MUX3_ARB_TIMEOUT_EN defined: hold cnt cleared on every new grant, +1 per GRANT cycle.
//    When cnt==HOLD_MAX-1 and no done/req drop, owner is force-released at that edge
//    (grant lasts exactly HOLD_MAX cycles); timeout=1 for the next cycle only; owner
//    becomes lowest priority as in normal release. done on the same edge wins: no pulse.
//  Not defined: no counter; grants held indefinitely; timeout tied to 0 (port kept).
// TESTING
//  1 Reset: arst=1 while grant_b=1 -> same cycle grant_*=0, select=00, busy=0.
//  2 req_b=1 alone, done=1 on 3rd grant cycle -> grant_b/select=01 for 3 cycles, then IDLE.
//  3 A,B,C req held, done=1 every grant cycle -> order A,B,C,A; select 10,01,00,10; busy stays 1.
//  4 req_a drops at grant cycle 2 without done -> grant_a falls next edge; pending req_c granted.
//  5 HOLD_MAX=4, req_c held, no done -> grant_c exactly 4 cycles, timeout 1-cycle pulse;
//    macro undefined -> grant_c held 20+ cycles, timeout=0.
//  6 HOLD_MAX=4, done on 4th cycle -> normal release, timeout stays 0.

Source files
------------

// File: rtl/mux3_rr_arbiter_if.sv
// mux3_rr_arbiter_if
// Bundle of request/grant signals between the requesting stages and the
// 3-way round-robin arbiter. The arbiter takes the slave view; the
// requesters (or a testbench) take the master view.
interface mux3_rr_arbiter_if;
  logic       req_a;
  logic       req_b;
  logic       req_c;
  logic       done;
  logic       grant_a;
  logic       grant_b;
  logic       grant_c;
  logic [1:0] select;
  logic       busy;
  logic       timeout;

  modport master (
    output req_a, req_b, req_c, done,
    input  grant_a, grant_b, grant_c, select, busy, timeout
  );

  modport slave (
    input  req_a, req_b, req_c, done,
    output grant_a, grant_b, grant_c, select, busy, timeout
  );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter
// Round-robin arbiter for one shared resource behind a 3:1 mux. Drives a
// one-hot grant and the mux select (10=A, 01=B, 00=C, 00 when idle). A grant
// is held until its owner raises done or drops its request; the released
// owner then becomes lowest priority for the arbitration on that same edge.
// Optional feature: define MUX3_ARB_TIMEOUT_EN to force-release a grant after
// HOLD_MAX cycles and pulse timeout for one cycle afterwards.
module mux3_rr_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int HOLD_W   = 5
) (
  input  logic               clk,
  input  logic               arst,
  mux3_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [1:0] IDX_A    = 2'd0;
  localparam logic [1:0] IDX_B    = 2'd1;
  localparam logic [1:0] IDX_C    = 2'd2;
  localparam logic [1:0] IDX_NONE = 2'd3;

  if (HOLD_MAX < 1 || HOLD_MAX > (2**HOLD_W) - 1) begin : gBadHold
    $error("HOLD_MAX must lie in 1..2**HOLD_W-1");
  end

  // First requester found when scanning A->B->C->A starting just after 'last'
  function automatic logic [1:0] pickNext(input logic [2:0] reqs, input logic [1:0] last);
    logic [1:0] o0, o1, o2, res;
    case (last)
      IDX_A:   begin o0 = IDX_B; o1 = IDX_C; o2 = IDX_A; end
      IDX_B:   begin o0 = IDX_C; o1 = IDX_A; o2 = IDX_B; end
      default: begin o0 = IDX_A; o1 = IDX_B; o2 = IDX_C; end
    endcase
    res = IDX_NONE;
    if (reqs[o2]) res = o2;
    if (reqs[o1]) res = o1;
    if (reqs[o0]) res = o0;
    return res;
  endfunction

  function automatic logic [1:0] selectOf(input logic [1:0] idx);
    case (idx)
      IDX_A:   return 2'b10;
      IDX_B:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] oneHot(input logic [1:0] idx);
    case (idx)
      IDX_A:   return 3'b001;
      IDX_B:   return 3'b010;
      IDX_C:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  state_e     state_q;
  logic [2:0] grant_q;
  logic [1:0] select_q;
  logic       busy_q;
  logic [1:0] lastOwner_q;

  logic [2:0] reqVec;
  logic [1:0] ownerIdx;
  logic       ownerReq;
  logic       releaseNow;
  logic       forceNow;
  logic [1:0] arbBase;
  logic [1:0] winner_d;

`ifdef MUX3_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
  logic [HOLD_W-1:0] holdCnt_q;
  logic              timeout_q;
`endif

  // Release decision for the current owner and the round-robin winner for this edge
  always_comb begin
    reqVec     = {bus.req_c, bus.req_b, bus.req_a};
    ownerIdx   = grant_q[0] ? IDX_A : (grant_q[1] ? IDX_B : IDX_C);
    ownerReq   = |(reqVec & grant_q);
    releaseNow = bus.done || !ownerReq;
    forceNow   = 1'b0;
`ifdef MUX3_ARB_TIMEOUT_EN
    forceNow   = !releaseNow && (holdCnt_q == HOLD_LAST);
`endif
    arbBase    = (state_q == GRANT) ? ownerIdx : lastOwner_q;
    winner_d   = pickNext(reqVec, arbBase);
  end

  // Grant FSM: all outputs are registered here so select always matches grant
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      grant_q     <= 3'b000;
      select_q    <= 2'b00;
      busy_q      <= 1'b0;
      lastOwner_q <= IDX_C;
`ifdef MUX3_ARB_TIMEOUT_EN
      holdCnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef MUX3_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (winner_d != IDX_NONE) begin
            state_q  <= GRANT;
            grant_q  <= oneHot(winner_d);
            select_q <= selectOf(winner_d);
            busy_q   <= 1'b1;
`ifdef MUX3_ARB_TIMEOUT_EN
            holdCnt_q <= '0;
`endif
          end
        end
        GRANT: begin
          if (releaseNow || forceNow) begin
            lastOwner_q <= ownerIdx;
`ifdef MUX3_ARB_TIMEOUT_EN
            timeout_q   <= forceNow;
            holdCnt_q   <= '0;
`endif
            if (winner_d != IDX_NONE) begin
              grant_q  <= oneHot(winner_d);
              select_q <= selectOf(winner_d);
            end else begin
              state_q  <= IDLE;
              grant_q  <= 3'b000;
              select_q <= 2'b00;
              busy_q   <= 1'b0;
            end
          end else begin
`ifdef MUX3_ARB_TIMEOUT_EN
            holdCnt_q <= holdCnt_q + HOLD_W'(1);
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_a = grant_q[0];
  assign bus.grant_b = grant_q[1];
  assign bus.grant_c = grant_q[2];
  assign bus.select  = select_q;
  assign bus.busy    = busy_q;
`ifdef MUX3_ARB_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// tb_mux3_rr_arbiter
// Directed bench for mux3_rr_arbiter (HOLD_MAX=4). A behavioural model of
// owner / round-robin pointer / hold length is compared with the DUT every
// negative clock edge; literal expectations pin the key scenarios.
// Works with MUX3_ARB_TIMEOUT_EN defined or undefined.
module tb_mux3_rr_arbiter;
  localparam int HOLD_MAX = 4;
  localparam int HOLD_W   = 5;
`ifdef MUX3_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst;
  bit   checkEn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mux3_rr_arbiter_if bus();

  mux3_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .HOLD_W(HOLD_W)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  // Model state: owner -1 = idle, 0=A 1=B 2=C
  int mOwner = -1;
  int mLast  = 2;
  int mHeld  = 0;
  bit mTo    = 1'b0;

  function automatic int modelPick(input int ptr, input bit ra, input bit rb, input bit rc);
    bit r[3];
    r[0] = ra; r[1] = rb; r[2] = rc;
    for (int k = 1; k <= 3; k++) begin
      if (r[(ptr + k) % 3]) return (ptr + k) % 3;
    end
    return -1;
  endfunction

  // Spec-level model: advance owner, pointer and hold length on each edge
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      mOwner = -1; mLast = 2; mHeld = 0; mTo = 1'b0;
    end else begin
      bit ownReq, rel, forced;
      int w;
      mTo = 1'b0;
      if (mOwner < 0) begin
        w = modelPick(mLast, bus.req_a, bus.req_b, bus.req_c);
        if (w >= 0) begin mOwner = w; mHeld = 1; end
      end else begin
        ownReq = (mOwner == 0) ? bus.req_a : ((mOwner == 1) ? bus.req_b : bus.req_c);
        rel    = bus.done || !ownReq;
        forced = TO_EN && !rel && (mHeld == HOLD_MAX);
        if (rel || forced) begin
          mLast  = mOwner;
          mOwner = modelPick(mLast, bus.req_a, bus.req_b, bus.req_c);
          mHeld  = 1;
          mTo    = forced;
        end else begin
          mHeld++;
        end
      end
    end
  end

  function automatic logic [6:0] dutVec();
    return {bus.grant_a, bus.grant_b, bus.grant_c, bus.select, bus.busy, bus.timeout};
  endfunction

  function automatic logic [6:0] modelVec();
    logic [1:0] sel;
    sel = (mOwner == 0) ? 2'b10 : ((mOwner == 1) ? 2'b01 : 2'b00);
    return {mOwner == 0, mOwner == 1, mOwner == 2, sel, mOwner >= 0, mTo};
  endfunction

  // Vectors are {grant_a, grant_b, grant_c, select[1:0], busy, timeout}
  task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%b expected=%b t=%0t", name, actual, expected, $time);
    end
  endtask

  // Continuous comparison of DUT against the model, away from the active edge
  always @(negedge clk) begin
    if (checkEn) checkOutput("model", dutVec(), modelVec());
  end

  task automatic applyStimulus(input bit a, input bit b, input bit c, input bit d);
    bus.req_a = a; bus.req_b = b; bus.req_c = c; bus.done = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  localparam logic [6:0] V_IDLE = 7'b000_00_1_0 & 7'b000_00_0_0;
  localparam logic [6:0] V_A    = 7'b100_10_1_0;
  localparam logic [6:0] V_B    = 7'b010_01_1_0;
  localparam logic [6:0] V_C    = 7'b001_00_1_0;

  // Directed scenarios with hand-computed expectations
  initial begin
    arst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    repeat (2) tick();
    checkOutput("reset", dutVec(), V_IDLE);
    arst = 1'b0;
    checkEn = 1'b1;

    // Lone B request, done with request drop during its third grant cycle
    applyStimulus(0, 1, 0, 0);
    tick(); checkOutput("t2_cyc1", dutVec(), V_B);
    tick(); checkOutput("t2_cyc2", dutVec(), V_B);
    tick(); checkOutput("t2_cyc3", dutVec(), V_B);
    applyStimulus(0, 0, 0, 1);
    tick(); checkOutput("t2_idle", dutVec(), V_IDLE);

    // Asynchronous reset while B owns the resource
    applyStimulus(0, 1, 0, 0);
    tick(); checkOutput("t1_pre", dutVec(), V_B);
    #1 arst = 1'b1;
    #1 checkOutput("t1_async", dutVec(), V_IDLE);
    applyStimulus(0, 0, 0, 0);
    tick();
    arst = 1'b0;

    // All three requesting with done every cycle: A,B,C,A back to back
    applyStimulus(1, 1, 1, 1);
    tick(); checkOutput("t3_a", dutVec(), V_A);
    tick(); checkOutput("t3_b", dutVec(), V_B);
    tick(); checkOutput("t3_c", dutVec(), V_C);
    tick(); checkOutput("t3_a2", dutVec(), V_A);
    applyStimulus(0, 0, 0, 0);
    tick(); checkOutput("t3_idle", dutVec(), V_IDLE);

    // A drops its request without done; waiting C takes over next edge
    applyStimulus(1, 0, 0, 0);
    tick(); checkOutput("t4_a1", dutVec(), V_A);
    applyStimulus(1, 0, 1, 0);
    tick(); checkOutput("t4_nopreempt", dutVec(), V_A);
    applyStimulus(0, 0, 1, 0);
    tick(); checkOutput("t4_c", dutVec(), V_C);

    // C holds without done while B waits
    applyStimulus(0, 1, 1, 0);
`ifdef MUX3_ARB_TIMEOUT_EN
    tick(); checkOutput("t5_c2", dutVec(), V_C);
    tick(); checkOutput("t5_c3", dutVec(), V_C);
    tick(); checkOutput("t5_c4", dutVec(), V_C);
    tick(); checkOutput("t5_forced", dutVec(), 7'b010_01_1_1);
    tick(); checkOutput("t5_pulse_end", dutVec(), V_B);
`else
    for (int i = 0; i < 20; i++) begin
      tick(); checkOutput("t5_hold", dutVec(), V_C);
    end
    applyStimulus(0, 1, 0, 0);
    tick(); checkOutput("t5_b", dutVec(), V_B);
`endif
    applyStimulus(0, 0, 0, 0);
    tick(); checkOutput("t5_idle", dutVec(), V_IDLE);

    // done on the fourth grant cycle wins over the hold limit: no pulse
    applyStimulus(1, 0, 0, 0);
    tick(); checkOutput("t6_a1", dutVec(), V_A);
    tick(); checkOutput("t6_a2", dutVec(), V_A);
    tick(); checkOutput("t6_a3", dutVec(), V_A);
    tick(); checkOutput("t6_a4", dutVec(), V_A);
    applyStimulus(1, 0, 0, 1);
    tick(); checkOutput("t6_regrant", dutVec(), V_A);
    applyStimulus(0, 0, 0, 0);
    tick(); checkOutput("t6_idle", dutVec(), V_IDLE);

    // done while idle changes nothing
    applyStimulus(0, 0, 0, 1);
    tick(); checkOutput("idle_done", dutVec(), V_IDLE);
    applyStimulus(0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
